temporizador_regressivo: RTL and testbench

//  Loadable countdown timer, the down-counting counterpart of the mod-M up counter.
//  A preset value (e.g. round/discussion seconds in the game flow) is loaded, then

---
 rtl/temporizador_regressivo.sv | 118 +++++++++++
 tb/tb_temporizador_regressivo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/temporizador_regressivo.sv
// Loadable countdown timer: a preset value is decremented once per prescaled tick while
// enabled, pausable mid-tick, with a sticky expiry level and a one-cycle expiry pulse.
module temporizador_regressivo #(
    parameter int M_TICK = 50_000_000,
    parameter int N_TICK = 26,
    parameter int N      = 7
) (
    input  logic          clock,
    input  logic          zera,
    input  logic          carrega,
    input  logic [N-1:0]  valor,
    input  logic          conta,
    output logic [N-1:0]  Q,
    output logic          tick,
    output logic          fim_pulso,
    output logic          fim,
    output logic [1:0]    db_estado
);

    // Handshake: none; carrega and conta are plain levels sampled on every rising edge.
    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        PAUSADO  = 2'b01,
        CONTANDO = 2'b10,
        ESGOTADO = 2'b11
    } estado_t;

    localparam logic [N_TICK-1:0] P_MAX = N_TICK'(M_TICK - 1);

    estado_t           r_estado;
    logic [N-1:0]      r_q;
    logic [N_TICK-1:0] r_p;
    logic              r_tick;
    logic              r_fim_pulso;

    estado_t           w_estado_next;
    logic [N-1:0]      w_q_next;
    logic [N_TICK-1:0] w_p_next;
    logic              w_tick_next;
    logic              w_fim_pulso_next;

    always_ff @(posedge clock or posedge zera) begin
        if (zera) begin
            r_estado    <= OCIOSO;
            r_q         <= '0;
            r_p         <= '0;
            r_tick      <= 1'b0;
            r_fim_pulso <= 1'b0;
        end else begin
            r_estado    <= w_estado_next;
            r_q         <= w_q_next;
            r_p         <= w_p_next;
            r_tick      <= w_tick_next;
            r_fim_pulso <= w_fim_pulso_next;
        end
    end

    always_comb begin
        w_estado_next    = r_estado;
        w_q_next         = r_q;
        w_p_next         = r_p;
        w_tick_next      = 1'b0;
        w_fim_pulso_next = 1'b0;

        if (carrega) begin
            // A load discards any prescaler match that would have landed on this edge.
            w_q_next = valor;
            w_p_next = '0;
            if (valor != '0) begin
                w_estado_next = PAUSADO;
            end else begin
                w_estado_next    = ESGOTADO;
                w_fim_pulso_next = 1'b1;
            end
        end else begin
            case (r_estado)
                OCIOSO: begin
                    w_estado_next = OCIOSO;
                end
                PAUSADO: begin
                    if (conta) begin
                        w_estado_next = CONTANDO;
                    end
                end
                CONTANDO: begin
                    if (!conta) begin
                        // Partial tick is kept so a pause does not stretch the period.
                        w_estado_next = PAUSADO;
                    end else if (r_p == P_MAX) begin
                        w_p_next    = '0;
                        w_q_next    = r_q - N'(1);
                        w_tick_next = 1'b1;
                        if (r_q == N'(1)) begin
                            w_estado_next    = ESGOTADO;
                            w_fim_pulso_next = 1'b1;
                        end
                    end else begin
                        w_p_next = r_p + N_TICK'(1);
                    end
                end
                ESGOTADO: begin
                    w_q_next = '0;
                    w_p_next = '0;
                end
                default: begin
                    w_estado_next = OCIOSO;
                end
            endcase
        end
    end

    assign Q         = r_q;
    assign tick      = r_tick;
    assign fim_pulso = r_fim_pulso;
    assign fim       = (r_estado == ESGOTADO);
    assign db_estado = r_estado;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Bench for temporizador_regressivo: directed scenarios plus random stimulus, all checked
// every cycle against a behavioural countdown model.
module tb_temporizador_regressivo;

    localparam int M_TICK = 4;
    localparam int N_TICK = 2;
    localparam int N      = 4;

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         zera = 1'b0;
    logic         carrega = 1'b0;
    logic [N-1:0] valor = '0;
    logic         conta = 1'b0;
    logic [N-1:0] Q;
    logic         tick;
    logic         fim_pulso;
    logic         fim;
    logic [1:0]   db_estado;

    always #5 clock = ~clock;

    temporizador_regressivo #(
        .M_TICK(M_TICK),
        .N_TICK(N_TICK),
        .N     (N)
    ) dut (
        .clock    (clock),
        .zera     (zera),
        .carrega  (carrega),
        .valor    (valor),
        .conta    (conta),
        .Q        (Q),
        .tick     (tick),
        .fim_pulso(fim_pulso),
        .fim      (fim),
        .db_estado(db_estado)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 paused, 2 running, 3 expired. elapsed counts run cycles in the current tick.
    int m_mode    = 0;
    int m_count   = 0;
    int m_elapsed = 0;
    bit m_tick    = 1'b0;
    bit m_fimp    = 1'b0;

    always @(posedge clock or posedge zera) begin
        if (zera) begin
            m_mode = 0; m_count = 0; m_elapsed = 0; m_tick = 0; m_fimp = 0;
        end else begin
            m_tick = 0;
            m_fimp = 0;
            if (carrega) begin
                m_count   = int'(valor);
                m_elapsed = 0;
                if (m_count == 0) begin
                    m_mode = 3;
                    m_fimp = 1;
                end else begin
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (conta) m_mode = 2;
            end else if (m_mode == 2) begin
                if (!conta) begin
                    m_mode = 1;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == M_TICK) begin
                        m_elapsed = 0;
                        m_count--;
                        m_tick = 1;
                        if (m_count == 0) begin
                            m_mode = 3;
                            m_fimp = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check("q",         32'(Q),         32'(m_count));
            check("tick",      32'(tick),      32'(m_tick));
            check("fim_pulso", 32'(fim_pulso), 32'(m_fimp));
            check("fim",       32'(fim),       32'(m_mode == 3));
            check("db_estado", 32'(db_estado), 32'(m_mode));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load(input logic [N-1:0] v);
        carrega = 1'b1;
        valor   = v;
        step(1);
        carrega = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 zera = 1'b1;
        step(2);
        zera = 1'b0;
        check_en = 1'b1;

        // 1: reset state, conta alone does nothing
        check("rst_q", 32'(Q), 0);
        check("rst_db", 32'(db_estado), 0);
        conta = 1'b1;
        step(5);
        check("idle_q", 32'(Q), 0);
        check("idle_db", 32'(db_estado), 0);
        conta = 1'b0;

        // 2: load 3, run to expiry; decrements at edges 5, 9, 13 after the load edge
        load(4'd3);
        check("ld3_q", 32'(Q), 3);
        check("ld3_db", 32'(db_estado), 1);
        conta = 1'b1;
        step(4);
        check("e4_q", 32'(Q), 3);
        check("e4_db", 32'(db_estado), 2);
        step(1);
        check("e5_q", 32'(Q), 2);
        check("e5_tick", 32'(tick), 1);
        step(4);
        check("e9_q", 32'(Q), 1);
        step(4);
        check("e13_q", 32'(Q), 0);
        check("e13_fimp", 32'(fim_pulso), 1);
        check("e13_fim", 32'(fim), 1);
        step(1);
        check("e14_fimp", 32'(fim_pulso), 0);
        check("e14_fim", 32'(fim), 1);
        step(3);
        conta = 1'b0;

        // 3: pause mid-tick keeps the partial tick
        load(4'd2);
        conta = 1'b1;
        step(3);
        conta = 1'b0;
        step(10);
        check("pause_q", 32'(Q), 2);
        check("pause_db", 32'(db_estado), 1);
        conta = 1'b1;
        step(2);
        check("resume2_q", 32'(Q), 2);
        step(1);
        check("resume3_q", 32'(Q), 1);
        step(6);
        conta = 1'b0;

        // 4: load 0 expires immediately
        load(4'd0);
        check("ld0_db", 32'(db_estado), 3);
        check("ld0_fimp", 32'(fim_pulso), 1);
        conta = 1'b1;
        step(6);
        check("ld0_q", 32'(Q), 0);
        conta = 1'b0;

        // 5: load on a prescaler-match edge wins over the decrement
        load(4'd5);
        conta = 1'b1;
        step(4);
        load(4'd9);
        check("ldm_q", 32'(Q), 9);
        check("ldm_tick", 32'(tick), 0);
        check("ldm_db", 32'(db_estado), 1);
        conta = 1'b0;
        step(2);

        // 6: async reset mid-tick, then clean restart from ESGOTADO
        load(4'd2);
        conta = 1'b1;
        step(3);
        #2 zera = 1'b1;
        #1;
        check("az_q", 32'(Q), 0);
        check("az_db", 32'(db_estado), 0);
        check("az_fimp", 32'(fim_pulso), 0);
        step(1);
        zera = 1'b0;
        conta = 1'b0;
        load(4'd0);
        load(4'd3);
        check("restart_q", 32'(Q), 3);
        conta = 1'b1;
        step(14);
        check("restart_fim", 32'(fim), 1);
        conta = 1'b0;

        // random phase
        for (int i = 0; i < 600; i++) begin
            carrega = ($urandom_range(0, 19) == 0);
            valor   = N'($urandom_range(0, 15));
            conta   = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 149) == 0) begin
                #2 zera = 1'b1;
                step(1);
                zera = 1'b0;
            end else begin
                step(1);
            end
        end
        carrega = 1'b0;
        conta   = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
